// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: fetch, decode, execute, memory, writeback.
// Optional CTRL_BRANCH_EXT_EN adds blt/bge/bltu/bgeu support.
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       illegal
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JALADR, S_JAL, S_HALT
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic [3:0] w_alu_dec;
    logic [3:0] w_br_alu;
    logic       w_br_take;
    logic       w_br_ok;
    logic       w_r_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_alu_dec = ALU_ADD;
        unique case (funct3)
            3'b000: w_alu_dec = (r_state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: w_alu_dec = ALU_SLL;
            3'b010: w_alu_dec = ALU_SLT;
            3'b011: w_alu_dec = ALU_SLTU;
            3'b100: w_alu_dec = ALU_XOR;
            3'b101: w_alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: w_alu_dec = ALU_OR;
            3'b111: w_alu_dec = ALU_AND;
        endcase
    end

    // Equality branches invert on funct3[0]; the compare-based ones flip again.
`ifdef CTRL_BRANCH_EXT_EN
    assign w_br_ok   = (funct3[2:1] != 2'b01);
    assign w_br_alu  = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
    assign w_br_take = zero ^ funct3[0] ^ funct3[2];
`else
    assign w_br_ok   = (funct3[2:1] == 2'b00);
    assign w_br_alu  = ALU_SUB;
    assign w_br_take = zero ^ funct3[0];
`endif

    assign w_r_ok = !funct7b5 || funct3 == 3'b000 || funct3 == 3'b101;

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_SW:            imm_src = 3'b001;
            OP_B:             imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        unique case (r_state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW:     w_next = (funct3 == 3'b010) ? S_MEMADR : S_HALT;
                    OP_R:             w_next = w_r_ok ? S_EXECR : S_HALT;
                    OP_I:             w_next = S_EXECI;
                    OP_LUI, OP_AUIPC: w_next = S_EXECI;
                    OP_B:             w_next = w_br_ok ? S_BRANCH : S_HALT;
                    OP_JAL:           w_next = S_JAL;
                    OP_JALR:          w_next = S_JALADR;
                    default:          w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = w_alu_dec;
                w_next      = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b = 2'b01;
                w_next    = S_ALUWB;
                if (op == OP_LUI) begin
                    alu_src_a = 2'b11;
                end else if (op == OP_AUIPC) begin
                    alu_src_a = 2'b01;
                end else begin
                    alu_src_a   = 2'b10;
                    alu_control = w_alu_dec;
                end
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = w_br_alu;
                w_pc_write  = w_br_take;
                w_next      = S_FETCH;
            end
            S_JALADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = S_JAL;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Enables are masked by rst_n so they drop the instant reset asserts.
    assign pc_write  = w_pc_write & rst_n;
    assign ir_write  = w_ir_write & rst_n;
    assign reg_write = w_reg_write & rst_n;
    assign mem_write = w_mem_write & rst_n;
    assign illegal   = (r_state == S_HALT);
endmodule

// File: tb/tb_mc_control_fsm.sv
// Random instruction stream against a step-script reference model.
// Per-instruction step lists are built from opcode rules and checked cycle by cycle.
module tb_mc_control_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, reg_write, mem_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       illegal;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_write(mem_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .alu_control(alu_control),
        .illegal(illegal)
    );

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4;
    localparam int P_MW = 5, P_XR = 6, P_XI = 7, P_WB = 8, P_BR = 9;
    localparam int P_JA = 10, P_J = 11, P_H = 12;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;

`ifdef CTRL_BRANCH_EXT_EN
    bit ext = 1'b1;
`else
    bit ext = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int n_rd = 0;
    int n_ldwb = 0;
    int plan[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {13'd0, pc_write, ir_write, reg_write, mem_write, adr_src,
                alu_src_a, alu_src_b, result_src, imm_src, alu_control,
                illegal};
    endfunction

    function automatic logic [3:0] alu_of(logic [2:0] f3, bit f7, bit rtype);
        case (f3)
            3'd0: return (rtype && f7) ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return f7 ? 4'd7 : 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    // Expected outputs for one step of the script under the current inputs.
    function automatic logic [31:0] exp_vec(int p, bit mr, bit en);
        logic pcw = 0, irw = 0, rw = 0, mw = 0, adr = 0, ill = 0;
        logic [1:0] a = 0, b = 0, rs = 0;
        logic [2:0] imm = 0;
        logic [3:0] alu = 0;
        case (op)
            SW:         imm = 3'd1;
            BR:         imm = 3'd2;
            JAL:        imm = 3'd3;
            LUI, AUIPC: imm = 3'd4;
            default:    imm = 3'd0;
        endcase
        case (p)
            P_F:   begin b = 2; rs = 2; irw = mr; pcw = mr; end
            P_D:   begin a = 1; b = 1; end
            P_MA:  begin a = 2; b = 1; end
            P_MR:  adr = 1;
            P_MWB: begin rs = 1; rw = 1; end
            P_MW:  begin adr = 1; mw = 1; end
            P_XR:  begin a = 2; alu = alu_of(funct3, funct7b5, 1'b1); end
            P_XI: begin
                b = 1;
                if (op == LUI) a = 3;
                else if (op == AUIPC) a = 1;
                else begin a = 2; alu = alu_of(funct3, funct7b5, 1'b0); end
            end
            P_WB:  rw = 1;
            P_BR: begin
                a = 2;
                case (funct3)
                    3'd4, 3'd5: alu = 4'd8;
                    3'd6, 3'd7: alu = 4'd9;
                    default:    alu = 4'd1;
                endcase
                case (funct3)
                    3'd0, 3'd5, 3'd7: pcw = zero;
                    default:          pcw = !zero;
                endcase
            end
            P_JA:  begin a = 2; b = 1; end
            P_J:   begin a = 1; b = 2; pcw = 1; end
            default: ill = 1;
        endcase
        if (!en) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
        return {13'd0, pcw, irw, rw, mw, adr, a, b, rs, imm, alu, ill};
    endfunction

    task automatic build_plan();
        plan.delete();
        plan = {P_F, P_D};
        case (op)
            LW, SW: begin
                if (funct3 != 3'd2) plan.push_back(P_H);
                else if (op[5]) plan = {plan, P_MA, P_MW};
                else plan = {plan, P_MA, P_MR, P_MWB};
            end
            RT: begin
                if (funct7b5 && funct3 != 3'd0 && funct3 != 3'd5)
                    plan.push_back(P_H);
                else plan = {plan, P_XR, P_WB};
            end
            IT, LUI, AUIPC: plan = {plan, P_XI, P_WB};
            BR: begin
                if (funct3 < 3'd2 || (ext && funct3 >= 3'd4))
                    plan.push_back(P_BR);
                else plan.push_back(P_H);
            end
            JAL:  plan = {plan, P_J, P_WB};
            JALR: plan = {plan, P_JA, P_J, P_WB};
            default: plan.push_back(P_H);
        endcase
    endtask

    task automatic step(input bit mr, input bit z);
        int p;
        @(negedge clk);
        mem_ready = mr;
        zero = z;
        #1;
        p = plan[0];
        chk($sformatf("st%0d op%07b f3=%0d", p, op, funct3),
            obs_vec(), exp_vec(p, mr, 1'b1));
        if (adr_src && !mem_write) n_rd++;
        if (reg_write && result_src == 2'b01) n_ldwb++;
        if (p == P_H) return;
        if ((p == P_F || p == P_MR || p == P_MW) && !mr) return;
        void'(plan.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_a", obs_vec(), exp_vec(P_F, 1'b1, 1'b0));
        @(negedge clk);
        #1;
        chk("rst_b", obs_vec(), exp_vec(P_F, 1'b1, 1'b0));
        mem_ready = 1'b0;
        rst_n = 1'b1;
        plan.delete();
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                             input bit f7, input int stall_p,
                             input int nstall, input bit rnd, input int zf);
        int budget = 0;
        int s = nstall;
        bit mr;
        bit z;
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        build_plan();
        while (plan.size() > 0 && plan[0] != P_H && budget < 100) begin
            mr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (plan[0] == stall_p && s > 0) begin
                mr = 1'b0;
                s--;
            end
            z = (zf < 0) ? 1'($urandom_range(0, 1)) : zf[0];
            step(mr, z);
            budget++;
        end
        if (budget >= 100) chk("budget", budget, 0);
        if (plan.size() > 0 && plan[0] == P_H) begin
            repeat (20) step(1'b1, 1'($urandom_range(0, 1)));
            do_reset();
        end
    endtask

    logic [6:0] ops[10];
    int guard;

    initial begin
        ops = '{LW, SW, RT, IT, BR, JAL, JALR, LUI, AUIPC, 7'd0};
        do_reset();
        run_instr(RT, 3'd0, 1'b0, -1, 0, 1'b0, -1);
        run_instr(RT, 3'd0, 1'b1, -1, 0, 1'b0, -1);
        n_rd = 0;
        n_ldwb = 0;
        run_instr(LW, 3'd2, 1'b0, P_MR, 3, 1'b0, -1);
        chk("lw_memread_cycles", n_rd, 4);
        chk("lw_wb_once", n_ldwb, 1);
        run_instr(SW, 3'd2, 1'b0, P_MW, 2, 1'b0, -1);
        run_instr(BR, 3'd1, 1'b0, -1, 0, 1'b0, 0);
        run_instr(BR, 3'd1, 1'b0, -1, 0, 1'b0, 1);
        run_instr(BR, 3'd0, 1'b0, -1, 0, 1'b0, 1);
        run_instr(IT, 3'd5, 1'b1, -1, 0, 1'b0, -1);
        run_instr(LUI, 3'd3, 1'b0, -1, 0, 1'b0, -1);
        run_instr(AUIPC, 3'd6, 1'b1, -1, 0, 1'b0, -1);
        run_instr(JAL, 3'd0, 1'b0, -1, 0, 1'b0, -1);
        run_instr(JALR, 3'd0, 1'b0, -1, 0, 1'b0, -1);
        run_instr(RT, 3'd1, 1'b1, -1, 0, 1'b0, -1);
        run_instr(7'b1111111, 3'd0, 1'b0, -1, 0, 1'b0, -1);
        run_instr(BR, 3'd4, 1'b0, -1, 0, 1'b0, 0);
        run_instr(BR, 3'd7, 1'b0, -1, 0, 1'b0, 1);

        // reset while a store is still waiting on memory
        op = SW;
        funct3 = 3'd2;
        funct7b5 = 1'b0;
        build_plan();
        guard = 0;
        while (plan[0] != P_MW && guard < 10) begin
            step(1'b1, 1'b0);
            guard++;
        end
        step(1'b0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("mw_before_rst", 32'(mem_write), 1);
        rst_n = 1'b0;
        #1;
        chk("mw_async_drop", 32'(mem_write), 0);
        chk("mw_rst_vec", obs_vec(), exp_vec(P_F, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        plan.delete();
        run_instr(RT, 3'd7, 1'b0, -1, 0, 1'b0, -1);

        for (int i = 0; i < 200; i++) begin
            int k;
            logic [6:0] o;
            logic [2:0] f;
            k = $urandom_range(0, 9);
            o = (k == 9) ? 7'($urandom) : ops[k];
            f = 3'($urandom_range(0, 7));
            if ((o == LW || o == SW) && $urandom_range(0, 3) != 0) f = 3'd2;
            run_instr(o, f, 1'($urandom_range(0, 1)), -1, 0, 1'b1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed by this document.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 op  in  7  instruction opcode (IR[6:0]).
REQ-005 funct3  in  3  IR[14:12].
REQ-006 funct7b5  in  1  IR[30].
REQ-007 zero  in  1  ALU flag (ALU result == 0).
REQ-008 mem_ready  in  1  memory access complete this cycle.
REQ-009 pc_write, ir_write, reg_write, mem_write  out  1 each  write enables.
REQ-010 adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
REQ-011 alu_src_a  out  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = RD1, 11 = constant 0.
REQ-012 alu_src_b  out  2  ALU B operand: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-013 result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-014 imm_src  out  3  immediate format: I = 000, S = 001, B = 010, J = 011, U = 100; combinational from op.
REQ-015 alu_control  out  4  ALU operation: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-016 illegal  out  1  sticky flag: unsupported instruction decoded.

Function
REQ-017 The block SHALL be a registered-state FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JALADR, JAL, HALT.
REQ-018 Outputs SHALL be combinational from the state, op, funct3, funct7b5, zero and mem_ready; any output not listed for a state SHALL be 0.
REQ-019 FETCH behaviour:
- Drive adr_src=0, A=00, B=10, ADD, result_src=10.
- Hold FETCH while mem_ready=0.
- When mem_ready=1, pulse ir_write=1 and pc_write=1 for one cycle, then go to DECODE.
REQ-020 DECODE SHALL drive A=01, B=01, ADD (branch/JAL target into ALUOut), then branch on op:
- 0000011 (lw, funct3 = 010 only) or 0100011 (sw, funct3 = 010 only) -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1100011 -> BRANCH.
- 1101111 -> JAL.
- 1100111 -> JALADR.
- 0110111 (LUI) or 0010111 (AUIPC) -> EXECI.
- Anything else -> HALT.
REQ-021 MEMADR SHALL drive A=10, B=01, ADD, then go to MEMREAD for lw or MEMWRITE for sw.
REQ-022 MEMREAD SHALL drive adr_src=1 and hold until mem_ready=1, then go to MEMWB.
REQ-023 MEMWB SHALL drive result_src=01, reg_write=1, then go to FETCH.
REQ-024 MEMWRITE SHALL drive adr_src=1 and mem_write=1 continuously until mem_ready=1, then go to FETCH.
REQ-025 EXECR and EXECI SHALL decode alu_control from funct3:
- 000: ADD, or SUB only when R-type and funct7b5=1.
- 001: SLL.
- 010: SLT.
- 011: SLTU.
- 100: XOR.
- 101: SRA if funct7b5=1, else SRL.
- 110: OR.
- 111: AND.
- Operands: EXECR A=10, B=00; EXECI A=10, B=01.
- LUI forces A=11, ADD; AUIPC forces A=01, ADD.
- Next state: ALUWB.
REQ-026 R-type with funct7b5=1 and funct3 not in {000, 101} SHALL go to HALT instead of EXECR.
REQ-027 ALUWB SHALL drive result_src=00, reg_write=1, then go to FETCH.
REQ-028 BRANCH SHALL drive A=10, B=00, result_src=00 and take the branch (pc_write=1) as follows, then go to FETCH:
- beq: SUB, taken if zero=1.
- bne: SUB, taken if zero=0.
- blt: SLT, taken if zero=0.
- bge: SLT, taken if zero=1.
- bltu: SLTU, taken if zero=0.
- bgeu: SLTU, taken if zero=1.
REQ-029 JALADR SHALL drive A=10, B=01, ADD, then go to JAL.
REQ-030 JAL SHALL drive A=01, B=10, ADD, result_src=00, pc_write=1, then go to ALUWB; the return address OldPC+4 lands in ALUOut.
REQ-031 HALT SHALL set illegal=1, drive all enables 0, and remain in HALT until reset.
REQ-032 Latencies with mem_ready tied high SHALL be: R/I/LUI/AUIPC 4 cycles, lw 5, sw 4, branch 3, jal 4, jalr 5.

Reset
REQ-033 While rst_n=0, the state SHALL be FETCH, illegal SHALL be 0, and all write enables SHALL be forced 0 asynchronously.
REQ-034 Reset asserted mid-MEMWRITE SHALL drop mem_write in the same cycle; no partial state is retained.

Configuration
REQ-035 With CTRL_BRANCH_EXT_EN defined, blt, bge, bltu and bgeu SHALL be supported per REQ-028.
REQ-036 Without CTRL_BRANCH_EXT_EN, only beq and bne SHALL be supported; branch funct3 values 100-111 go to HALT from DECODE.

Verification
REQ-037 add x3,x1,x2 with mem_ready=1 -> states FETCH, DECODE, EXECR (alu_control=0000), ALUWB with reg_write=1; next FETCH on cycle 5.
REQ-038 lw with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles; reg_write=1 with result_src=01 exactly once.
REQ-039 bne with zero=0 -> pc_write=1 in BRANCH; repeat with zero=1 -> pc_write=0 in BRANCH.
REQ-040 srai (op=0010011, funct3=101, funct7b5=1) -> alu_control=0111 in EXECI.
REQ-041 op=1111111 -> HALT, illegal=1 stays high for 20 cycles; rst_n pulse low -> illegal=0, state FETCH.
REQ-042 blt with CTRL_BRANCH_EXT_EN undefined -> HALT after DECODE; with it defined and zero=0 -> alu_control=1000, pc_write=1.
